// File: rtl/serial_div.sv
// serial_div: sequential signed divider. Restoring division on operand
// magnitudes produces one quotient bit per clock, then a single fix-up cycle
// applies signs, saturates the quotient and raises data_ready.
module serial_div #(
  parameter int N_BITS_A      = 8,
  parameter int N_BITS_B      = 8,
  parameter int N_BITS_RESULT = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_BITS_A-1:0]      a,
  input  logic [N_BITS_B-1:0]      b,
  input  logic                     start,
  output logic                     data_ready,
  output logic [N_BITS_RESULT-1:0] result,
  output logic [N_BITS_B-1:0]      remainder,
  output logic                     overflow,
  output logic                     div_by_zero
);

  localparam int CW = $clog2(N_BITS_A + 1);
  localparam int QW = ((N_BITS_A > N_BITS_RESULT) ? N_BITS_A : N_BITS_RESULT) + 1;
  localparam logic [QW-1:0] MAX_POS = (QW'(1) << (N_BITS_RESULT - 1)) - QW'(1);
  localparam logic [QW-1:0] MIN_MAG = QW'(1) << (N_BITS_RESULT - 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_e;

  state_e                   state_q, state_d;
  logic [N_BITS_A-1:0]      dividend_q, dividend_d;
  logic [N_BITS_B-1:0]      divisor_q, divisor_d;
  logic [N_BITS_B-1:0]      partial_q, partial_d;
  logic [CW-1:0]            count_q, count_d;
  logic                     signQ_q, signQ_d;
  logic                     signR_q, signR_d;
  logic                     zero_q, zero_d;
  logic                     ready_q, ready_d;
  logic [N_BITS_RESULT-1:0] result_q, result_d;
  logic [N_BITS_B-1:0]      remainder_q, remainder_d;
  logic                     overflow_q, overflow_d;
  logic                     dbz_q, dbz_d;

  logic [N_BITS_B:0]        shifted;
  logic                     fits;
  logic [N_BITS_A-1:0]      aMag;
  logic [N_BITS_B-1:0]      bMag;
  logic [QW-1:0]            qExt;
  logic [N_BITS_RESULT-1:0] qTrunc;

  // Datapath helpers: operand magnitudes, the trial shift/compare of one
  // restoring step, and the zero-extended quotient magnitude for saturation.
  always_comb begin
    aMag    = a[N_BITS_A-1] ? ((~a) + N_BITS_A'(1)) : a;
    bMag    = b[N_BITS_B-1] ? ((~b) + N_BITS_B'(1)) : b;
    shifted = {partial_q, dividend_q[N_BITS_A-1]};
    fits    = (shifted >= {1'b0, divisor_q});
    qExt    = {{(QW - N_BITS_A){1'b0}}, dividend_q};
    qTrunc  = qExt[N_BITS_RESULT-1:0];
  end

  // Next-state and next-output logic for the IDLE/RUN/FIX/DONE sequencer.
  always_comb begin
    state_d     = state_q;
    dividend_d  = dividend_q;
    divisor_d   = divisor_q;
    partial_d   = partial_q;
    count_d     = count_q;
    signQ_d     = signQ_q;
    signR_d     = signR_q;
    zero_d      = zero_q;
    ready_d     = ready_q;
    result_d    = result_q;
    remainder_d = remainder_q;
    overflow_d  = overflow_q;
    dbz_d       = dbz_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          dividend_d = aMag;
          divisor_d  = bMag;
          partial_d  = '0;
          count_d    = CW'(N_BITS_A);
          signQ_d    = a[N_BITS_A-1] ^ b[N_BITS_B-1];
          signR_d    = a[N_BITS_A-1];
          zero_d     = (b == '0);
          ready_d    = 1'b0;
          overflow_d = 1'b0;
          dbz_d      = 1'b0;
          state_d    = RUN;
        end
      end

      RUN: begin
        // The partial remainder stays below the divisor magnitude, so the
        // subtraction can be done at divisor width without losing bits.
        if (fits) begin
          partial_d = shifted[N_BITS_B-1:0] - divisor_q;
        end else begin
          partial_d = shifted[N_BITS_B-1:0];
        end
        dividend_d = {dividend_q[N_BITS_A-2:0], fits};
        count_d    = count_q - CW'(1);
        if (count_q == CW'(1)) begin
          state_d = FIX;
        end
      end

      FIX: begin
        ready_d = 1'b1;
        state_d = DONE;
        if (zero_q) begin
          result_d    = '0;
          remainder_d = '0;
          dbz_d       = 1'b1;
          overflow_d  = 1'b0;
        end else begin
          remainder_d = signR_q ? ((~partial_q) + N_BITS_B'(1)) : partial_q;
          if (!signQ_q && (qExt > MAX_POS)) begin
            result_d   = {1'b0, {(N_BITS_RESULT - 1){1'b1}}};
            overflow_d = 1'b1;
          end else if (signQ_q && (qExt > MIN_MAG)) begin
            result_d   = {1'b1, {(N_BITS_RESULT - 1){1'b0}}};
            overflow_d = 1'b1;
          end else begin
            result_d   = signQ_q ? ((~qTrunc) + N_BITS_RESULT'(1)) : qTrunc;
            overflow_d = 1'b0;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset discards any operation in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      dividend_q  <= '0;
      divisor_q   <= '0;
      partial_q   <= '0;
      count_q     <= '0;
      signQ_q     <= 1'b0;
      signR_q     <= 1'b0;
      zero_q      <= 1'b0;
      ready_q     <= 1'b0;
      result_q    <= '0;
      remainder_q <= '0;
      overflow_q  <= 1'b0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      dividend_q  <= dividend_d;
      divisor_q   <= divisor_d;
      partial_q   <= partial_d;
      count_q     <= count_d;
      signQ_q     <= signQ_d;
      signR_q     <= signR_d;
      zero_q      <= zero_d;
      ready_q     <= ready_d;
      result_q    <= result_d;
      remainder_q <= remainder_d;
      overflow_q  <= overflow_d;
      dbz_q       <= dbz_d;
    end
  end

  assign data_ready  = ready_q;
  assign result      = result_q;
  assign remainder   = remainder_q;
  assign overflow    = overflow_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_serial_div.sv
// tb_serial_div: scoreboard bench for serial_div. The driver pushes the
// arithmetically expected result for each accepted start; an independent
// monitor pops and compares on every rising edge of data_ready.
module tb_serial_div;

  logic       clk;
  logic       reset;
  logic [7:0] a;
  logic [7:0] b;
  logic       start;
  logic       data_ready;
  logic [7:0] result;
  logic [7:0] remainder;
  logic       overflow;
  logic       div_by_zero;

  typedef struct {
    int         aIn;
    int         bIn;
    logic [7:0] res;
    logic [7:0] rem;
    logic       ovf;
    logic       dbz;
  } exp_t;

  exp_t sbQ[$];
  int   checks = 0;
  int   errors = 0;
  logic prevReady = 1'b0;

  serial_div #(
    .N_BITS_A(8),
    .N_BITS_B(8),
    .N_BITS_RESULT(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .a(a),
    .b(b),
    .start(start),
    .data_ready(data_ready),
    .result(result),
    .remainder(remainder),
    .overflow(overflow),
    .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain integer division truncating toward zero, clamped to 8 bits.
  function automatic exp_t model(int av, int bv);
    exp_t e;
    int   q;
    int   r;
    e.aIn = av;
    e.bIn = bv;
    e.ovf = 1'b0;
    e.dbz = 1'b0;
    if (bv == 0) begin
      e.res = 8'd0;
      e.rem = 8'd0;
      e.dbz = 1'b1;
    end else begin
      q = av / bv;
      r = av % bv;
      if (q > 127) begin
        q = 127;
        e.ovf = 1'b1;
      end else if (q < -128) begin
        q = -128;
        e.ovf = 1'b1;
      end
      e.res = 8'(q);
      e.rem = 8'(r);
    end
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: compares each newly presented result against the scoreboard head.
  always @(negedge clk) begin
    if (reset && data_ready && !prevReady) begin
      if (sbQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_result actual=%0d required=none", $signed(result));
      end else begin
        exp_t e;
        e = sbQ.pop_front();
        checkOutput($sformatf("result(%0d/%0d)", e.aIn, e.bIn), 32'(result), 32'(e.res));
        checkOutput($sformatf("remainder(%0d/%0d)", e.aIn, e.bIn), 32'(remainder), 32'(e.rem));
        checkOutput($sformatf("overflow(%0d/%0d)", e.aIn, e.bIn), 32'(overflow), 32'(e.ovf));
        checkOutput($sformatf("div_by_zero(%0d/%0d)", e.aIn, e.bIn), 32'(div_by_zero), 32'(e.dbz));
      end
    end
    prevReady = data_ready;
  end

  // One division: optional ignored start pulse during RUN, optional reset abort.
  task automatic applyStimulus(input int av, input int bv, input int glitchCycle, input int resetCycle);
    int cycles;
    bit done;
    bit aborted;
    @(negedge clk);
    a     = 8'(av);
    b     = 8'(bv);
    start = 1'b1;
    sbQ.push_back(model(av, bv));
    @(posedge clk);
    #1;
    start = 1'b0;
    checkOutput("ready_cleared_on_start", 32'(data_ready), 32'd0);
    cycles  = 0;
    done    = 1'b0;
    aborted = 1'b0;
    while (!done && cycles < 20) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      cycles++;
      if (cycles == resetCycle) begin
        reset = 1'b0;
        #1;
        checkOutput("reset_data_ready", 32'(data_ready), 32'd0);
        checkOutput("reset_result", 32'(result), 32'd0);
        checkOutput("reset_remainder", 32'(remainder), 32'd0);
        checkOutput("reset_overflow", 32'(overflow), 32'd0);
        checkOutput("reset_div_by_zero", 32'(div_by_zero), 32'd0);
        void'(sbQ.pop_back());
        repeat (2) @(negedge clk);
        reset   = 1'b1;
        aborted = 1'b1;
        done    = 1'b1;
      end else begin
        if (cycles == glitchCycle) begin
          a     = 8'd1;
          b     = 8'd1;
          start = 1'b1;
        end
        if (data_ready) done = 1'b1;
      end
    end
    if (!aborted) begin
      checkOutput($sformatf("latency(%0d/%0d)", av, bv), 32'(cycles), 32'd9);
      if (!done) void'(sbQ.pop_back());
    end
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b0;
    a     = 8'd0;
    b     = 8'd0;
    repeat (3) @(negedge clk);
    checkOutput("reset_state_ready", 32'(data_ready), 32'd0);
    checkOutput("reset_state_result", 32'(result), 32'd0);
    checkOutput("reset_state_remainder", 32'(remainder), 32'd0);
    checkOutput("reset_state_overflow", 32'(overflow), 32'd0);
    checkOutput("reset_state_dbz", 32'(div_by_zero), 32'd0);
    reset = 1'b1;

    applyStimulus(100, 7, 0, 0);
    applyStimulus(-100, 7, 0, 0);
    applyStimulus(100, -7, 0, 0);
    applyStimulus(-128, -1, 0, 0);
    applyStimulus(5, 0, 0, 0);
    applyStimulus(-128, 1, 0, 0);
    applyStimulus(-128, -128, 0, 0);
    applyStimulus(127, -128, 0, 0);
    applyStimulus(-1, 2, 0, 0);
    applyStimulus(0, 5, 0, 0);
    applyStimulus(127, 1, 0, 0);
    applyStimulus(-128, 0, 0, 0);

    applyStimulus(100, 7, 3, 0);
    applyStimulus(-5, 3, 0, 4);
    applyStimulus(77, -9, 0, 0);

    for (int i = 0; i < 300; i++) begin
      int av;
      int bv;
      av = int'($urandom_range(0, 255)) - 128;
      bv = int'($urandom_range(0, 255)) - 128;
      if ($urandom_range(0, 19) == 0) bv = 0;
      applyStimulus(av, bv, 0, 0);
    end

    repeat (3) @(negedge clk);
    checkOutput("scoreboard_drained", 32'(sbQ.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
